// File: rtl/pll_dyn_pkg.sv
// Shared types, default divider set, legal ranges and select encoders
// for the PLL dynamic reconfiguration controller.
package pll_dyn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST,
    ST_WAIT_LOCK,
    ST_CHECK
  } state_t;

  // Raw divider values as offered on the configuration port.
  typedef struct packed {
    logic [6:0] idiv;
    logic [6:0] fbdiv;
    logic [7:0] mdiv;
    logic [7:0] odiv0;
  } div_set_t;

  // Encoded values as presented to the PLL select inputs.
  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [6:0] mdsel;
    logic [6:0] odsel0;
  } sel_set_t;

  // 50 MHz in -> 66.67 MHz out.
  localparam logic [6:0] DEF_IDIV  = 7'd1;
  localparam logic [6:0] DEF_FBDIV = 7'd1;
  localparam logic [7:0] DEF_MDIV  = 8'd32;
  localparam logic [7:0] DEF_ODIV0 = 8'd24;

  localparam logic [6:0] IDIV_MIN  = 7'd1;
  localparam logic [6:0] IDIV_MAX  = 7'd64;
  localparam logic [6:0] FBDIV_MIN = 7'd1;
  localparam logic [6:0] FBDIV_MAX = 7'd64;
  localparam logic [7:0] MDIV_MIN  = 8'd2;
  localparam logic [7:0] MDIV_MAX  = 8'd128;
  localparam logic [7:0] ODIV_MIN  = 8'd1;
  localparam logic [7:0] ODIV_MAX  = 8'd128;

  // 64 - div, low 6 bits (64 encodes as 0).
  function automatic logic [5:0] enc_div6(input logic [6:0] div);
    logic [6:0] t;
    t = 7'd64 - div;
    return t[5:0];
  endfunction

  // 128 - div, low 7 bits (128 encodes as 0).
  function automatic logic [6:0] enc_div7(input logic [7:0] div);
    logic [7:0] t;
    t = 8'd128 - div;
    return t[6:0];
  endfunction

  function automatic logic div_set_legal(input div_set_t s);
    return (s.idiv  >= IDIV_MIN)  && (s.idiv  <= IDIV_MAX)  &&
           (s.fbdiv >= FBDIV_MIN) && (s.fbdiv <= FBDIV_MAX) &&
           (s.mdiv  >= MDIV_MIN)  && (s.mdiv  <= MDIV_MAX)  &&
           (s.odiv0 >= ODIV_MIN)  && (s.odiv0 <= ODIV_MAX);
  endfunction

  function automatic sel_set_t encode_set(input div_set_t s);
    sel_set_t r;
    r.idsel  = enc_div6(s.idiv);
    r.fbdsel = enc_div6(s.fbdiv);
    r.mdsel  = enc_div7(s.mdiv);
    r.odsel0 = enc_div7(s.odiv0);
    return r;
  endfunction

  localparam div_set_t DEF_DIV_SET = '{idiv: DEF_IDIV, fbdiv: DEF_FBDIV,
                                       mdiv: DEF_MDIV, odiv0: DEF_ODIV0};
  localparam sel_set_t DEF_SEL_SET = encode_set(DEF_DIV_SET);

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Valid/ready divider-set offer port of the PLL reconfiguration controller.
interface pll_dyn_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [6:0] cfg_idiv;
  logic [6:0] cfg_fbdiv;
  logic [7:0] cfg_mdiv;
  logic [7:0] cfg_odiv0;

  modport master (output cfg_valid, cfg_idiv, cfg_fbdiv, cfg_mdiv, cfg_odiv0,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_idiv, cfg_fbdiv, cfg_mdiv, cfg_odiv0,
                  output cfg_ready);
endinterface

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the PLL LOCK output into the sys_clk domain.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);
  logic meta_reg;
  logic sync_reg;

  // Shift the asynchronous input through two flops; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;
endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL dynamic reconfiguration controller: accepts a divider set, validates
// it, loads the encoded selects and runs the PLL through reset and relock.
// Runs the same sequence with the default set after power-up.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  pll_dyn_ctrl_if.slave cfg,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [6:0]    mdsel,
  output logic [6:0]    odsel0,
  output logic          busy,
  output logic          locked,
  output logic          done,
  output logic          err
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RW-1:0] RST_LAST    = RW'(RESET_CYCLES - 1);
  localparam logic [RW-1:0] RST_MAX     = RW'(RESET_CYCLES);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(LOCK_STABLE);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX      = TW'(LOCK_TIMEOUT);

  state_t          state_reg, state_next;
  logic [RW-1:0]   rst_cnt_reg, rst_cnt_next;
  logic [SW-1:0]   stable_cnt_reg, stable_cnt_next;
  logic [TW-1:0]   timeout_cnt_reg, timeout_cnt_next;
  div_set_t        cfg_reg, cfg_next;
  sel_set_t        sel_reg, sel_next;
  logic            pll_reset_reg, pll_reset_next;
  logic            locked_reg, locked_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic            lock_s;

  lock_sync u_lock_sync (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  // State and output registers; reset restarts the power-up relock sequence.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg       <= ST_RST;
      rst_cnt_reg     <= '0;
      stable_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      cfg_reg         <= DEF_DIV_SET;
      sel_reg         <= DEF_SEL_SET;
      pll_reset_reg   <= 1'b1;
      locked_reg      <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rst_cnt_reg     <= rst_cnt_next;
      stable_cnt_reg  <= stable_cnt_next;
      timeout_cnt_reg <= timeout_cnt_next;
      cfg_reg         <= cfg_next;
      sel_reg         <= sel_next;
      pll_reset_reg   <= pll_reset_next;
      locked_reg      <= locked_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
    end
  end

  // Next-state logic for the accept / check / reset / relock sequence.
  always_comb begin
    state_next       = state_reg;
    rst_cnt_next     = rst_cnt_reg;
    stable_cnt_next  = stable_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    cfg_next         = cfg_reg;
    sel_next         = sel_reg;
    pll_reset_next   = pll_reset_reg;
    locked_next      = locked_reg;
    done_next        = 1'b0;
    err_next         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Track lock loss and recovery without starting a new sequence.
        if (lock_s) begin
          if (stable_cnt_reg != STABLE_MAX) stable_cnt_next = stable_cnt_reg + 1'b1;
          if (stable_cnt_reg >= STABLE_LAST) locked_next = 1'b1;
        end else begin
          stable_cnt_next = '0;
          locked_next     = 1'b0;
        end
        if (cfg.cfg_valid) begin
          cfg_next   = '{idiv: cfg.cfg_idiv, fbdiv: cfg.cfg_fbdiv,
                         mdiv: cfg.cfg_mdiv, odiv0: cfg.cfg_odiv0};
          state_next = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (div_set_legal(cfg_reg)) begin
          sel_next        = encode_set(cfg_reg);
          pll_reset_next  = 1'b1;
          locked_next     = 1'b0;
          rst_cnt_next    = '0;
          stable_cnt_next = '0;
          state_next      = ST_RST;
        end else begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end

      ST_RST: begin
        if (rst_cnt_reg == RST_LAST) begin
          pll_reset_next   = 1'b0;
          stable_cnt_next  = '0;
          timeout_cnt_next = '0;
          state_next       = ST_WAIT_LOCK;
        end else if (rst_cnt_reg != RST_MAX) begin
          rst_cnt_next = rst_cnt_reg + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (timeout_cnt_reg != TO_MAX) timeout_cnt_next = timeout_cnt_reg + 1'b1;
        if (!lock_s) begin
          stable_cnt_next = '0;
        end else if (stable_cnt_reg != STABLE_MAX) begin
          stable_cnt_next = stable_cnt_reg + 1'b1;
        end
        // Success is checked first so it wins a same-cycle timeout.
        if (lock_s && (stable_cnt_reg == STABLE_LAST)) begin
          locked_next = 1'b1;
          done_next   = 1'b1;
          state_next  = ST_IDLE;
        end else if (timeout_cnt_reg == TO_LAST) begin
          locked_next = 1'b0;
          err_next    = 1'b1;
          state_next  = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign cfg.cfg_ready = (state_reg == ST_IDLE);
  assign busy          = (state_reg != ST_IDLE);
  assign pll_reset     = pll_reset_reg;
  assign locked        = locked_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign idsel         = sel_reg.idsel;
  assign fbdsel        = sel_reg.fbdsel;
  assign mdsel         = sel_reg.mdsel;
  assign odsel0        = sel_reg.odsel0;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl with a behavioural PLL lock model.
module tb_pll_dyn_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] idsel;
  logic [5:0] fbdsel;
  logic [6:0] mdsel;
  logic [6:0] odsel0;
  logic       busy;
  logic       locked;
  logic       done;
  logic       err;
  logic [25:0] sel_now;

  pll_dyn_ctrl_if cfg_bus();

  pll_dyn_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg       (cfg_bus),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .idsel     (idsel),
    .fbdsel    (fbdsel),
    .mdsel     (mdsel),
    .odsel0    (odsel0),
    .busy      (busy),
    .locked    (locked),
    .done      (done),
    .err       (err)
  );

  assign sel_now = {idsel, fbdsel, mdsel, odsel0};

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int mis_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // PLL model: lock drops while reset is high and rises lock_delay cycles
  // after release; an optional one-cycle glitch at lock_rise_cyc+glitch_off.
  bit lock_en       = 1'b1;
  int lock_delay    = 500;
  int glitch_off    = -1;
  int lk_cnt        = 0;
  bit lock_up       = 1'b0;
  int lock_rise_cyc = 0;

  initial begin
    pll_lock = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (pll_reset !== 1'b0 || !lock_en) begin
        lock_up = 1'b0;
        lk_cnt  = 0;
      end else if (!lock_up) begin
        if (lk_cnt >= lock_delay) begin
          lock_up       = 1'b1;
          lock_rise_cyc = cyc;
        end else begin
          lk_cnt++;
        end
      end
      pll_lock = lock_up && !(glitch_off >= 0 && cyc == lock_rise_cyc + glitch_off);
    end
  end

  // Event monitor: time stamps of reset edges and done/err pulses.
  bit prev_rst = 1'b1;
  int rst_rise_cyc = 0, rst_fall_cyc = 0, rst_fall_cnt = 0;
  int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  logic locked_at_done, ready_at_done, locked_at_err, ready_at_err;

  initial begin
    forever begin
      @(negedge sys_clk);
      if (pll_reset === 1'b1 && !prev_rst) rst_rise_cyc = cyc;
      if (pll_reset === 1'b0 && prev_rst) begin
        rst_fall_cyc = cyc;
        rst_fall_cnt++;
      end
      prev_rst = (pll_reset !== 1'b0);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc       = cyc;
        locked_at_done = locked;
        ready_at_done  = cfg_bus.cfg_ready;
      end
      if (err === 1'b1) begin
        err_cnt++;
        err_cyc       = cyc;
        locked_at_err = locked;
        ready_at_err  = cfg_bus.cfg_ready;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int evt_count(input int which);
    case (which)
      0:       return done_cnt;
      1:       return err_cnt;
      default: return rst_fall_cnt;
    endcase
  endfunction

  // which: 0 = done, 1 = err, 2 = pll_reset falling.
  task automatic wait_evt(input int which, input int budget, input string tag);
    int c0;
    bit hit;
    c0  = evt_count(which);
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      tick();
      if (evt_count(which) != c0) hit = 1'b1;
    end
    check_val(tag, 32'(hit), 32'd1);
  endtask

  task automatic apply_set(input logic [6:0] i, input logic [6:0] f,
                           input logic [7:0] m, input logic [7:0] o);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_idiv  = i;
    cfg_bus.cfg_fbdiv = f;
    cfg_bus.cfg_mdiv  = m;
    cfg_bus.cfg_odiv0 = o;
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  localparam logic [25:0] DEF_SELS = {6'd63, 6'd63, 7'd96, 7'd104};

  logic [6:0]  lg_i[3]   = '{7'd1, 7'd64, 7'd5};
  logic [6:0]  lg_f[3]   = '{7'd1, 7'd64, 7'd3};
  logic [7:0]  lg_m[3]   = '{8'd40, 8'd128, 8'd2};
  logic [7:0]  lg_o[3]   = '{8'd8, 8'd128, 8'd1};
  logic [25:0] lg_sel[3] = '{{6'd63, 6'd63, 7'd88, 7'd120},
                             {6'd0, 6'd0, 7'd0, 7'd0},
                             {6'd59, 6'd61, 7'd126, 7'd127}};

  logic [6:0] il_i[5] = '{7'd1, 7'd0, 7'd1, 7'd1, 7'd1};
  logic [6:0] il_f[5] = '{7'd1, 7'd1, 7'd65, 7'd1, 7'd1};
  logic [7:0] il_m[5] = '{8'd1, 8'd32, 8'd32, 8'd32, 8'd129};
  logic [7:0] il_o[5] = '{8'd8, 8'd24, 8'd24, 8'd0, 8'd24};

  initial begin
    int rel_cyc, d0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_idiv  = '0;
    cfg_bus.cfg_fbdiv = '0;
    cfg_bus.cfg_mdiv  = '0;
    cfg_bus.cfg_odiv0 = '0;
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    repeat (3) tick();

    // Reset state.
    check_val("rst_pll_reset", 32'(pll_reset), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd1);
    check_val("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    check_val("rst_locked", 32'(locked), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_idsel", 32'(idsel), 32'd63);
    check_val("rst_fbdsel", 32'(fbdsel), 32'd63);
    check_val("rst_mdsel", 32'(mdsel), 32'd96);
    check_val("rst_odsel0", 32'(odsel0), 32'd104);

    // Power-up sequence with the default set; lock 500 cycles after release.
    sys_rst_n = 1'b1;
    rel_cyc   = cyc;
    wait_evt(0, 2000, "pu_done_seen");
    check_val("pu_reset_width", 32'(rst_fall_cyc - rel_cyc), 32'd16);
    check_val("pu_lock_latency", 32'(done_cyc - lock_rise_cyc), 32'd258);
    check_val("pu_locked", 32'(locked_at_done), 32'd1);
    check_val("pu_ready_at_done", 32'(ready_at_done), 32'd1);
    check_val("pu_sels", 32'(sel_now), 32'(DEF_SELS));

    // Legal sets, including the range boundaries.
    lock_delay = 40;
    for (int k = 0; k < 3; k++) begin
      apply_set(lg_i[k], lg_f[k], lg_m[k], lg_o[k]);
      check_val($sformatf("lg%0d_busy", k), 32'(busy), 32'd1);
      check_val($sformatf("lg%0d_ready", k), 32'(cfg_bus.cfg_ready), 32'd0);
      check_val($sformatf("lg%0d_reset_in_check", k), 32'(pll_reset), 32'd0);
      tick();
      check_val($sformatf("lg%0d_reset_rise", k), 32'(pll_reset), 32'd1);
      check_val($sformatf("lg%0d_sels", k), 32'(sel_now), 32'(lg_sel[k]));
      check_val($sformatf("lg%0d_locked_drop", k), 32'(locked), 32'd0);
      wait_evt(0, 2000, $sformatf("lg%0d_done_seen", k));
      check_val($sformatf("lg%0d_reset_width", k), 32'(rst_fall_cyc - rst_rise_cyc), 32'd16);
      check_val($sformatf("lg%0d_lock_latency", k), 32'(done_cyc - lock_rise_cyc), 32'd258);
      check_val($sformatf("lg%0d_locked", k), 32'(locked_at_done), 32'd1);
      check_val($sformatf("lg%0d_ready_at_done", k), 32'(ready_at_done), 32'd1);
    end

    // Illegal sets: err one cycle after accept, no PLL reset, selects kept.
    for (int k = 0; k < 5; k++) begin
      apply_set(il_i[k], il_f[k], il_m[k], il_o[k]);
      check_val($sformatf("il%0d_busy", k), 32'(busy), 32'd1);
      tick();
      check_val($sformatf("il%0d_err", k), 32'(err), 32'd1);
      check_val($sformatf("il%0d_ready", k), 32'(cfg_bus.cfg_ready), 32'd1);
      check_val($sformatf("il%0d_no_reset", k), 32'(pll_reset), 32'd0);
      check_val($sformatf("il%0d_sels_kept", k), 32'(sel_now), 32'({6'd59, 6'd61, 7'd126, 7'd127}));
      tick();
      check_val($sformatf("il%0d_err_pulse", k), 32'(err), 32'd0);
    end

    // Lock glitch at stable count 200: glitch on pll_lock at k+200 makes
    // lock_s low in cycle k+202, the count restarts at edge k+203 and
    // reaches 256 at edge k+459.
    glitch_off = 200;
    d0 = done_cnt;
    apply_set(7'd1, 7'd1, 8'd32, 8'd24);
    wait_evt(0, 3000, "gl_done_seen");
    check_val("gl_lock_latency", 32'(done_cyc - lock_rise_cyc), 32'd459);
    check_val("gl_single_done", 32'(done_cnt - d0), 32'd1);
    glitch_off = -1;

    // Lock never arrives: err after 65536 cycles in WAIT_LOCK.
    lock_en = 1'b0;
    apply_set(7'd2, 7'd2, 8'd64, 8'd16);
    wait_evt(1, 70000, "to_err_seen");
    check_val("to_latency", 32'(err_cyc - rst_fall_cyc), 32'd65536);
    check_val("to_locked", 32'(locked_at_err), 32'd0);
    check_val("to_ready", 32'(ready_at_err), 32'd1);
    check_val("to_sels_kept", 32'(sel_now), 32'({6'd62, 6'd62, 7'd64, 7'd112}));
    lock_en = 1'b1;
    repeat (5) tick();

    // Reset mid-WAIT_LOCK: immediate return to reset values, default rerun.
    lock_delay = 100;
    apply_set(7'd1, 7'd1, 8'd40, 8'd8);
    wait_evt(2, 100, "ar_reset_fall_seen");
    repeat (20) tick();
    sys_rst_n = 1'b0;
    #1;
    check_val("ar_pll_reset", 32'(pll_reset), 32'd1);
    check_val("ar_busy", 32'(busy), 32'd1);
    check_val("ar_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    check_val("ar_locked", 32'(locked), 32'd0);
    check_val("ar_sels", 32'(sel_now), 32'(DEF_SELS));
    repeat (2) tick();
    lock_delay = 500;
    sys_rst_n  = 1'b1;
    rel_cyc    = cyc;
    wait_evt(0, 2000, "ar_done_seen");
    check_val("ar_reset_width", 32'(rst_fall_cyc - rel_cyc), 32'd16);
    check_val("ar_lock_latency", 32'(done_cyc - lock_rise_cyc), 32'd258);
    check_val("ar_locked_after", 32'(locked_at_done), 32'd1);
    check_val("ar_sels_after", 32'(sel_now), 32'(DEF_SELS));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
